// File: rtl/apb_reg_slave.sv
// apb_reg_slave: zero-wait APB completer with RW/RO/W1C/counter registers and a protocol checker
module apb_reg_slave #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic [DATAWIDTH-1:0] pwdata,
  output logic [DATAWIDTH-1:0] prdata,
  output logic                 irq,
  output logic                 prot_err
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int WW = ADDRWIDTH - 2;
  state_t state_q, state_d, phase;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [WW-1:0] word;
  logic wr_q, wr_d, wrap_q, wrap_d, prot_q, prot_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d, ctrl_q, ctrl_d, data_q, data_d, count_q, count_d;
  logic [DATAWIDTH-1:0] prdata_q, prdata_d, status, rd_val;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic viol, commit, mapped, clr, wrap;
  always_comb begin
    phase = state_q == SETUP ? ACCESS : (psel && !penable) ? SETUP : IDLE;
    viol = (phase == IDLE && penable) ||
           (phase == ACCESS && (!psel || !penable || paddr != addr_q || pwrite != wr_q || pwdata != wdata_q));
    state_d = viol ? IDLE : phase;
    addr_d = phase == SETUP ? paddr : addr_q;
    wr_d = phase == SETUP ? pwrite : wr_q;
    wdata_d = phase == SETUP ? pwdata : wdata_q;
    commit = phase == ACCESS && !viol && pwrite;
    word = paddr[ADDRWIDTH-1:2];
    mapped = word <= WW'(5);
    status = '0;
    status[15:8] = wr_cnt_q;
    status[0] = ctrl_q[0];
    rd_val = word == WW'(0) ? ctrl_q :
             word == WW'(1) ? data_q :
             word == WW'(2) ? status :
             word == WW'(3) ? DATAWIDTH'(wrap_q) :
             word == WW'(4) ? count_q :
             word == WW'(5) ? DATAWIDTH'(ID_VALUE) : '0;
    prdata_d = (psel && !penable && !pwrite) ? rd_val : prdata_q;
    ctrl_d = (commit && word == WW'(0)) ? (pwdata & ~DATAWIDTH'(4)) : ctrl_q;
    data_d = (commit && word == WW'(1)) ? pwdata : data_q;
    clr = commit && word == WW'(0) && pwdata[2];
    wrap = !clr && ctrl_q[0] && (&count_q);
    count_d = clr ? '0 : ctrl_q[0] ? count_q + DATAWIDTH'(1) : count_q;
    wrap_d = wrap || (wrap_q && !(commit && word == WW'(3) && pwdata[0]));
    wr_cnt_d = wr_cnt_q + 8'(commit && mapped);
    prot_d = prot_q || viol;
  end
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      ctrl_q <= '0;
      data_q <= '0;
      count_q <= '0;
      wrap_q <= 1'b0;
      wr_cnt_q <= '0;
      prdata_q <= '0;
      prot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      wdata_q <= wdata_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      count_q <= count_d;
      wrap_q <= wrap_d;
      wr_cnt_q <= wr_cnt_d;
      prdata_q <= prdata_d;
      prot_q <= prot_d;
    end
  end
  assign prdata = prdata_q;
  assign irq = wrap_q & ctrl_q[1];
  assign prot_err = prot_q;
endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- APB completer (slave) that terminates transfers issued by the team's APB driver. Holds a small register bank with RW, RO, W1C and counter registers, and is the DUT for RAL front-door/mirror checks.
- Zero-wait-state: no pready, no pslverr. Every transfer completes in one SETUP plus one ACCESS cycle.
- Also tracks the APB phase in a small FSM and flags protocol violations from the initiator.

Parameters:
- ADDRWIDTH, 8, paddr width; byte addresses, word-aligned decode on paddr[ADDRWIDTH-1:2].
- DATAWIDTH, 32, pwdata/prdata width; must be >= 16.
- ID_VALUE, 32'hA5B0_0001, constant returned by ID register (truncated to DATAWIDTH).

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- presetn  input  1  reset; one clock; synchronous, active-low.
- psel  input  1  slave select.
- penable  input  1  access phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDRWIDTH  byte address.
- pwdata  input  DATAWIDTH  write data.
- prdata  output  DATAWIDTH  registered read data.
- irq  output  1  INTR[0] & CTRL[1], combinational from flops.
- prot_err  output  1  sticky protocol-violation flag.

Behaviour:
- Register map (offset, access, reset):
  - 0x00 CTRL, RW, 0. bit0 = CNT_EN, bit1 = IRQ_EN, bit2 = CNT_CLR (self-clearing, always reads 0), other bits RW storage.
  - 0x04 DATA, RW, 0.
  - 0x08 STATUS, RO, 0. bit0 mirrors CTRL[0]; bits[15:8] = WR_CNT, the number of committed writes to mapped addresses mod 256; other bits 0.
  - 0x0C INTR, W1C, 0. bit0 = CNT_WRAP; other bits read 0.
  - 0x10 COUNT, RO, 0. Free-running counter.
  - 0x14 ID, RO, ID_VALUE.
  - Any other offset: reads 0, writes ignored and not counted.
- Phase FSM: IDLE -> SETUP on psel & !penable; SETUP -> ACCESS unconditionally next cycle; ACCESS -> SETUP if psel & !penable, else IDLE. Reset state is IDLE.
- Write commit: at the rising edge where state = ACCESS & psel & penable & pwrite, using paddr/pwdata sampled in that cycle.
- Read capture: at the rising edge where psel & !penable & !pwrite (SETUP edge), prdata loads the decoded register value of that cycle. prdata is therefore stable for the whole ACCESS cycle and holds until the next read SETUP. Writes never change prdata.
- prot_err is set (sticky until reset) on any of:
  - penable = 1 while state = IDLE;
  - state = ACCESS and (psel = 0 or penable = 0);
  - paddr, pwrite or pwdata differing in ACCESS from the values latched at SETUP.
  - When a violation occurs, the transfer is not committed and the FSM returns to IDLE.
- COUNT arithmetic (per cycle, priority high to low):
  - CTRL write with pwdata[2] = 1: COUNT <= 0 and no wrap flag that cycle.
  - Otherwise, if CNT_EN = 1: COUNT <= COUNT + 1, modulo 2^DATAWIDTH. On all-ones -> 0, CNT_WRAP is set.
  - A CTRL write that changes CNT_EN takes effect from the next cycle.
- INTR W1C: a write with pwdata[0] = 1 clears CNT_WRAP. If a wrap occurs in the same cycle, set wins and the bit stays 1.
- WR_CNT increments on each committed write to a mapped address, including RO targets (the write is ignored but counted). It wraps 255 -> 0.
- Reset (presetn = 0 at rising edge): all registers, prdata, prot_err and WR_CNT clear to 0; FSM to IDLE; irq = 0. A transfer in flight is discarded; mid-reset writes do not commit.
- No combinational path from APB inputs to outputs.

Test Plan:
- Reset, then read every offset -> prdata 0 for 0x00-0x10, ID_VALUE at 0x14, 0 at 0x18; prot_err = 0, irq = 0.
- Write DATA = 0xDEAD_BEEF, read it back -> 0xDEADBEEF. Then read STATUS -> bits[15:8] = 0x01.
- Write CTRL = 0x3, wait 10 cycles, read COUNT -> value equals the cycles elapsed from the commit edge to the SETUP edge (exact, counted by the bench). Write CTRL = 0x7, then read COUNT -> small value restarted from 0; CTRL reads back 0x3.
- Force COUNT near wrap (reset, write CTRL = 0x3, let it run with DATAWIDTH = 16 override to 0xFFFF) -> INTR = 0x1, irq = 1. Write INTR = 0x1 -> INTR = 0, irq = 0. W1C on the wrap cycle -> INTR stays 1.
- Drive psel = 1, penable = 1 from IDLE -> prot_err = 1, no register change. Change paddr between SETUP and ACCESS on a write -> target unchanged, prot_err stays 1 until reset.
- Assert presetn low during the ACCESS phase of a write to DATA = 0x1234 -> after reset, DATA reads 0 and WR_CNT = 0.
